// File: rtl/retospect_pkg.sv
// Shared types and constants for the retospect configuration loader.
//   bl_state_t        : loader state encoding
//   CRC8_POLY         : CRC-8 polynomial (x^8 + x^2 + x + 1)
//   CHAIN_LEN_DEFAULT : scan-chain length of the full array (6x8 + 50x19)
//   crc8_step         : one bitwise CRC-8 update
package retospect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ARM  = 2'd2,
    ST_DONE = 2'd3
  } bl_state_t;

  localparam logic [7:0]  CRC8_POLY         = 8'h07;
  localparam int unsigned CHAIN_LEN_DEFAULT = 998;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/retospect_crc8_serial.sv
// Bit-serial CRC-8 accumulator (init 0x00).
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the CRC at 0x00 (wins over en)
//   en         : fold bit_in into the CRC this cycle
//   bit_in     : serial data bit
//   crc        : current CRC value
module retospect_crc8_serial
  import retospect_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/retospect_bitloader.sv
// Configuration front-end: accepts bytes over valid/ready and shifts them
// LSB-first onto the array scan chain, then pulses reset_nn once.
//   start/abort          : begin (IDLE/DONE) / cancel (LOAD) a load
//   in_data/in_valid     : byte stream in; in_ready when a byte is taken
//   config_en/cfg_bs     : registered chain enable and serial bit
//   cfg_ret              : chain tail, sampled on config_en cycles
//   reset_nn             : one-cycle arm pulse after a complete load
//   busy/done            : LOAD or ARM / DONE
//   bit_count            : chain bits shifted in the current load
//   tx_crc/rx_crc        : CRC-8 of bits sent / bits returned
module retospect_bitloader
  import retospect_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             config_en,
  output logic             cfg_bs,
  input  logic             cfg_ret,
  output logic             reset_nn,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count,
  output logic [7:0]       tx_crc,
  output logic [7:0]       rx_crc
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

  bl_state_t        state_q, state_d;
  logic [6:0]       sh_q, sh_d;    // byte bits still to go after the one on cfg_bs
  logic [2:0]       rem_q, rem_d;  // number of valid bits in sh_q
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cfg_en_q, cfg_en_d;
  logic             cfg_bs_q, cfg_bs_d;
  logic             rst_nn_q, rst_nn_d;
  logic             crc_clr;
  logic [CNT_W-1:0] left_w;

  assign left_w   = LEN_C - cnt_q;
  assign in_ready = (state_q == ST_LOAD) && (rem_q == 3'd0) && (cnt_q < LEN_C);

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    cfg_en_d = 1'b0;
    cfg_bs_d = cfg_bs_q;
    rst_nn_d = 1'b0;
    crc_clr  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d = ST_LOAD;
          sh_d    = '0;
          rem_d   = '0;
          cnt_d   = '0;
          crc_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == LEN_C) begin
          state_d  = ST_ARM;
          rst_nn_d = 1'b1;
        end else if (rem_q != 3'd0) begin
          cfg_en_d = 1'b1;
          cfg_bs_d = sh_q[0];
          sh_d     = {1'b0, sh_q[6:1]};
          rem_d    = rem_q - 3'd1;
          cnt_d    = cnt_q + CNT_W'(1);
        end else if (in_valid && in_ready) begin
          // Bit 0 goes straight to the output register so a byte accepted
          // at h is on the chain from h+1; only the chain's remaining
          // length is kept from a final partial byte.
          cfg_en_d = 1'b1;
          cfg_bs_d = in_data[0];
          sh_d     = in_data[7:1];
          rem_d    = (left_w >= CNT_W'(8)) ? 3'd7 : 3'(left_w - CNT_W'(1));
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_ARM:  state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      cfg_en_q <= 1'b0;
      cfg_bs_q <= 1'b0;
      rst_nn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      cfg_en_q <= cfg_en_d;
      cfg_bs_q <= cfg_bs_d;
      rst_nn_q <= rst_nn_d;
    end
  end

  // Both CRCs fold on the edge where the chain captures cfg_bs.
  retospect_crc8_serial u_tx_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clr),
    .en     (cfg_en_q),
    .bit_in (cfg_bs_q),
    .crc    (tx_crc)
  );

  retospect_crc8_serial u_rx_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (crc_clr),
    .en     (cfg_en_q),
    .bit_in (cfg_ret),
    .crc    (rx_crc)
  );

  assign config_en = cfg_en_q;
  assign cfg_bs    = cfg_bs_q;
  assign reset_nn  = rst_nn_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_ARM);
  assign done      = (state_q == ST_DONE);
  assign bit_count = cnt_q;

endmodule
